// File: rtl/player_input_if.sv
// Press-generator bus: board key, difficulty and enable in; press pulses and LFSR debug state out.
interface player_input_if #(
  parameter int LFSR_W = 10,
  parameter int DIFF_W = 3
) ();
  logic              key_n;
  logic [DIFF_W-1:0] difficulty;
  logic              enable;
  logic              human_press;
  logic              cpu_press;
  logic [LFSR_W-1:0] lfsr_out;

  modport master (
    output key_n, difficulty, enable,
    input  human_press, cpu_press, lfsr_out
  );

  modport slave (
    input  key_n, difficulty, enable,
    output human_press, cpu_press, lfsr_out
  );
endinterface

// File: rtl/player_input.sv
// Human key edge detector plus LFSR-driven computer press generator.
// Optional cpu_press cooldown is enabled by defining PRESS_COOLDOWN_EN.
module player_input #(
  parameter int LFSR_W   = 10,
  parameter int DIFF_W   = 3,
  parameter int COOLDOWN = 4
) (
  input logic           clk,
  input logic           reset,
  player_input_if.slave bus
);
  typedef enum logic {IDLE, HELD} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic              pressed;
  logic              human_press_q, human_press_d;
  logic              cpu_press_q, cpu_press_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] thr;
  logic              cool_zero;

  if (LFSR_W != 10 || DIFF_W >= LFSR_W || COOLDOWN < 1) begin : g_param_check
    $error("player_input: unsupported parameter combination");
  end

  // The key is asynchronous, so it crosses a two-flop synchronizer before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.key_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  // The FSM follows the key even while disabled, so a key held across enable rising never pulses.
  always_comb begin
    state_d       = state_q;
    human_press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d       = HELD;
          human_press_d = bus.enable;
        end
      end
      HELD: begin
        if (!pressed) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lfsr_d      = {lfsr_q[LFSR_W-2:0], lfsr_q[9] ^ lfsr_q[6]};
  assign thr         = {bus.difficulty, {(LFSR_W-DIFF_W){1'b0}}};
  assign cpu_press_d = bus.enable && cool_zero && (lfsr_q < thr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      human_press_q <= 1'b0;
      cpu_press_q   <= 1'b0;
      lfsr_q        <= {{(LFSR_W-1){1'b0}}, 1'b1};
    end else begin
      state_q       <= state_d;
      human_press_q <= human_press_d;
      cpu_press_q   <= cpu_press_d;
      lfsr_q        <= lfsr_d;
    end
  end

`ifdef PRESS_COOLDOWN_EN
  localparam int COOL_W = $clog2(COOLDOWN + 1);

  logic [COOL_W-1:0] cool_q, cool_d;

  assign cool_zero = (cool_q == '0);

  // Loading on the firing edge yields exactly COOLDOWN low cycles before the next pulse can qualify.
  always_comb begin
    cool_d = cool_q;
    if (!bus.enable) begin
      cool_d = '0;
    end else if (cpu_press_d) begin
      cool_d = COOL_W'(COOLDOWN);
    end else if (!cool_zero) begin
      cool_d = cool_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cool_q <= '0;
    else       cool_q <= cool_d;
  end
`else
  assign cool_zero = 1'b1;
`endif

  assign bus.human_press = human_press_q;
  assign bus.cpu_press   = cpu_press_q;
  assign bus.lfsr_out    = lfsr_q;
endmodule

// File: tb/tb_player_input.sv
// Directed bench for player_input: per-cycle scoreboard of human_press, cpu_press and lfsr_out.
module tb_player_input;
  localparam int LFSR_W   = 10;
  localparam int DIFF_W   = 3;
  localparam int COOLDOWN = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  player_input_if #(.LFSR_W(LFSR_W), .DIFF_W(DIFF_W)) pif ();

  player_input #(.LFSR_W(LFSR_W), .DIFF_W(DIFF_W), .COOLDOWN(COOLDOWN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic              h_q[$];
  logic              c_q[$];
  logic [LFSR_W-1:0] l_q[$];

  logic [LFSR_W-1:0] m_lfsr = 10'h001;
  int                m_cool = 0;

  logic [LFSR_W-1:0] lfsr_tab [8] = '{10'h001, 10'h002, 10'h004, 10'h008,
                                      10'h010, 10'h020, 10'h040, 10'h081};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the coming edge are pushed before it and popped after it.
  task automatic tick(input logic exp_h);
    logic              ec;
    logic [LFSR_W-1:0] nl;
    if (reset) begin
      ec     = 1'b0;
      nl     = 10'h001;
      m_cool = 0;
    end else begin
      ec = pif.enable && (m_cool == 0) && (m_lfsr < {pif.difficulty, 7'b0});
`ifdef PRESS_COOLDOWN_EN
      if (!pif.enable)     m_cool = 0;
      else if (ec)         m_cool = COOLDOWN;
      else if (m_cool > 0) m_cool = m_cool - 1;
`endif
      nl = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
    m_lfsr = nl;
    h_q.push_back(reset ? 1'b0 : exp_h);
    c_q.push_back(ec);
    l_q.push_back(nl);
    @(posedge clk);
    #1;
    check("human_press", 32'(pif.human_press), 32'(h_q.pop_front()));
    check("cpu_press",   32'(pif.cpu_press),   32'(c_q.pop_front()));
    check("lfsr_out",    32'(pif.lfsr_out),    32'(l_q.pop_front()));
  endtask

  initial begin
    int cpu_seen;
    int since;
    int min_gap;
    int b2b;

    pif.key_n      = 1'b1;
    pif.difficulty = '0;
    pif.enable     = 1'b0;
    reset          = 1'b1;

    // Reset state and LFSR sequence
    tick(1'b0);
    check("reset_lfsr", 32'(pif.lfsr_out), 32'(lfsr_tab[0]));
    reset = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick(1'b0);
      check("lfsr_seq", 32'(pif.lfsr_out), 32'(lfsr_tab[i]));
    end

    // Held key gives one pulse two edges after the first sampling edge
    pif.enable = 1'b1;
    pif.key_n  = 1'b0;
    tick(1'b0); tick(1'b0); tick(1'b1);
    repeat (7) tick(1'b0);
    pif.key_n = 1'b1;
    repeat (4) tick(1'b0);
    pif.key_n = 1'b0;
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0);
    pif.key_n = 1'b1;
    repeat (4) tick(1'b0);

    // Key held while enable rises: no pulse until a fresh press
    pif.enable = 1'b0;
    pif.key_n  = 1'b0;
    repeat (4) tick(1'b0);
    pif.enable = 1'b1;
    repeat (4) tick(1'b0);
    pif.key_n = 1'b1;
    repeat (4) tick(1'b0);
    pif.key_n = 1'b0;
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0);
    pif.key_n = 1'b1;
    repeat (4) tick(1'b0);

    // Difficulty 0 never fires; difficulty 7 fires right after reset release
    reset = 1'b1;
    tick(1'b0);
    reset    = 1'b0;
    cpu_seen = 0;
    repeat (2046) begin
      tick(1'b0);
      if (pif.cpu_press) cpu_seen++;
    end
    check("diff0_never", 32'(cpu_seen), 32'd0);
    pif.difficulty = 3'd7;
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    tick(1'b0);
    check("cpu_first", 32'(pif.cpu_press), 32'd1);

    // Pulse spacing at maximum difficulty
    since   = -1;
    min_gap = 1000;
    b2b     = 0;
    repeat (200) begin
      tick(1'b0);
      if (pif.cpu_press) begin
        if (since == 0) b2b++;
        if (since >= 0 && since < min_gap) min_gap = since;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
    end
`ifdef PRESS_COOLDOWN_EN
    check("cooldown_gap", 32'(min_gap >= COOLDOWN), 32'd1);
`else
    check("back_to_back", 32'(b2b > 0), 32'd1);
`endif

    // Enable falling forces cpu_press low on the next edge
    pif.enable = 1'b0;
    tick(1'b0);
    check("enable_off", 32'(pif.cpu_press), 32'd0);
    repeat (3) tick(1'b0);

    // Reset while the key is held and cpu is active; key re-syncs afterwards
    pif.enable = 1'b1;
    pif.key_n  = 1'b0;
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0);
    reset = 1'b1;
    tick(1'b0);
    check("midreset_lfsr", 32'(pif.lfsr_out), 32'h001);
    check("midreset_cpu",  32'(pif.cpu_press), 32'd0);
    reset = 1'b0;
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0);
    pif.key_n = 1'b1;
    repeat (3) tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
